// File: rtl/if_fetch_unit.sv
// Purpose : instruction-fetch stage; fetches words over the shared bus and presents if_pc/if_insn to ID.
// Latency : one instruction per cycle with a zero-wait bus; each bus wait state adds one busy cycle.
// Backpr. : stall parks a returned word in a one-entry hold buffer (HOLD); busy asks the controller to stall.
//
// Ports:
//   clk, reset_              clock, asynchronous active-low reset
//   stall, flush, new_pc     pipeline controller: hold IF / discard IF and redirect
//   br_taken, br_addr        decoder redirect, honoured only in a delivery cycle (one delay slot)
//   if_pc, if_insn, if_en    IF register towards ID (if_pc is the instruction word address + 1)
//   busy                     fetch not complete this cycle
//   bus_req_, bus_grnt_      bus request/grant, active-low
//   bus_addr, bus_as_        fetch word address and address strobe (active-low)
//   bus_rdy_, bus_rd_data    read-data ready (active-low) and read data
module if_fetch_unit #(
  parameter int                     WORD_ADDR_W  = 30,
  parameter int                     WORD_W       = 32,
  parameter logic [WORD_ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] new_pc,
  input  logic                   br_taken,
  input  logic [WORD_ADDR_W-1:0] br_addr,
  output logic [WORD_ADDR_W-1:0] if_pc,
  output logic [WORD_W-1:0]      if_insn,
  output logic                   if_en,
  output logic                   busy,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_as_,
  input  logic                   bus_rdy_,
  input  logic [WORD_W-1:0]      bus_rd_data
);

  localparam logic [WORD_W-1:0] ISA_NOP = '0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACCESS,
    HOLD,
    DRAIN
  } state_t;

  state_t                 state;
  logic [WORD_ADDR_W-1:0] fetch_pc;

  // One-entry buffer for a word that returned while ID was stalled.
  logic [WORD_W-1:0]      hold_insn;
  logic [WORD_ADDR_W-1:0] hold_pc;
  logic                   hold_br_taken;
  logic [WORD_ADDR_W-1:0] hold_br_addr;

  logic [WORD_ADDR_W-1:0] fetch_pc_inc;
  logic                   rdy;

  // Wraps modulo 2^WORD_ADDR_W by construction.
  assign fetch_pc_inc = fetch_pc + WORD_ADDR_W'(1);
  assign rdy          = ~bus_rdy_;

  // Bus-side outputs decode directly from state so the bus sees them in the
  // same cycle the state is entered.
  always_comb begin
    bus_req_ = 1'b1;
    bus_as_  = 1'b1;
    bus_addr = '0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b1;
      end
      REQ: begin
        bus_req_ = 1'b0;
        busy     = 1'b1;
      end
      ACCESS: begin
        bus_req_ = 1'b0;
        bus_as_  = 1'b0;
        bus_addr = fetch_pc;
        busy     = ~rdy;
      end
      HOLD: begin
        bus_req_ = 1'b0;
      end
      DRAIN: begin
        bus_req_ = 1'b0;
        bus_as_  = 1'b0;
        bus_addr = fetch_pc;
        busy     = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state         <= IDLE;
      fetch_pc      <= RESET_VECTOR;
      if_pc         <= RESET_VECTOR;
      if_insn       <= ISA_NOP;
      if_en         <= 1'b0;
      hold_insn     <= '0;
      hold_pc       <= '0;
      hold_br_taken <= 1'b0;
      hold_br_addr  <= '0;
    end else if (flush) begin
      // Flush wins over everything: kill the IF register, retarget the fetch
      // and drop anything parked in the hold buffer.
      if_en         <= 1'b0;
      if_insn       <= ISA_NOP;
      fetch_pc      <= new_pc;
      hold_insn     <= '0;
      hold_pc       <= '0;
      hold_br_taken <= 1'b0;
      hold_br_addr  <= '0;
      case (state)
        // A read is still outstanding on the bus; wait it out before
        // issuing the new address.
        ACCESS:  state <= rdy ? ACCESS : DRAIN;
        HOLD:    state <= ACCESS;
        DRAIN:   state <= DRAIN;
        default: state <= state;
      endcase
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end

        REQ: begin
          if (!bus_grnt_) begin
            state <= ACCESS;
          end
        end

        ACCESS: begin
          if (rdy && !stall) begin
            // Delivery. This word is the delay slot of any branch the
            // decoder reports now, so it stays valid and only the next
            // fetch address is redirected.
            if_insn  <= bus_rd_data;
            if_pc    <= fetch_pc_inc;
            if_en    <= 1'b1;
            fetch_pc <= br_taken ? br_addr : fetch_pc_inc;
          end else if (rdy && stall) begin
            hold_insn     <= bus_rd_data;
            hold_pc       <= fetch_pc_inc;
            hold_br_taken <= br_taken;
            hold_br_addr  <= br_addr;
            state         <= HOLD;
          end
        end

        HOLD: begin
          if (!stall) begin
            if_insn       <= hold_insn;
            if_pc         <= hold_pc;
            if_en         <= 1'b1;
            fetch_pc      <= hold_br_taken ? hold_br_addr : hold_pc;
            hold_insn     <= '0;
            hold_pc       <= '0;
            hold_br_taken <= 1'b0;
            hold_br_addr  <= '0;
            state         <= ACCESS;
          end
        end

        DRAIN: begin
          // The returning word belongs to the flushed stream; drop it.
          if (rdy) begin
            state <= ACCESS;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Purpose : directed self-checking bench for if_fetch_unit with a wait-state programmable memory responder.
// Latency : checks registered outputs 1 time unit after posedge, bus-side outputs 1 unit after negedge.
// Backpr. : drives stall/flush/branch directly; memory word k reads as 0x1000 + k.
module tb_if_fetch_unit;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk;
  logic          reset_;
  logic          stall;
  logic          flush;
  logic [AW-1:0] new_pc;
  logic          br_taken;
  logic [AW-1:0] br_addr;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_insn;
  logic          if_en;
  logic          busy;
  logic          bus_req_;
  logic          bus_grnt_;
  logic [AW-1:0] bus_addr;
  logic          bus_as_;
  logic          bus_rdy_;
  logic [DW-1:0] bus_rd_data;

  int tests;
  int fails;
  int wait_states;
  int wcnt;

  if_fetch_unit dut (
    .clk         (clk),
    .reset_      (reset_),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .if_pc       (if_pc),
    .if_insn     (if_insn),
    .if_en       (if_en),
    .busy        (busy),
    .bus_req_    (bus_req_),
    .bus_grnt_   (bus_grnt_),
    .bus_addr    (bus_addr),
    .bus_as_     (bus_as_),
    .bus_rdy_    (bus_rdy_),
    .bus_rd_data (bus_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: decides ready for the coming posedge at each negedge.
  always @(negedge clk) begin
    if (!reset_) begin
      bus_rdy_    = 1'b1;
      bus_rd_data = '0;
      wcnt        = 0;
    end else if (!bus_as_) begin
      if (wcnt >= wait_states) begin
        bus_rdy_    = 1'b0;
        bus_rd_data = 32'h1000 + {2'b00, bus_addr};
        wcnt        = 0;
      end else begin
        bus_rdy_ = 1'b1;
        wcnt     = wcnt + 1;
      end
    end else begin
      bus_rdy_ = 1'b1;
      wcnt     = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done;
    int busy_cnt;
    tests       = 0;
    fails       = 0;
    wait_states = 0;
    wcnt        = 0;
    reset_      = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    new_pc      = '0;
    br_taken    = 1'b0;
    br_addr     = '0;
    bus_grnt_   = 1'b0;
    bus_rdy_    = 1'b1;
    bus_rd_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_insn", if_insn, 0);
    chk("rst_if_en", if_en, 0);
    chk("rst_busy", busy, 1);
    chk("rst_bus_req_", bus_req_, 1);
    chk("rst_bus_as_", bus_as_, 1);
    chk("rst_bus_addr", bus_addr, 0);
    reset_ = 1'b1;

    // IDLE -> REQ -> ACCESS, then zero-wait streaming
    tick();
    chk("req_bus_req_", bus_req_, 0);
    chk("req_bus_as_", bus_as_, 1);
    chk("req_busy", busy, 1);
    tick();
    chk("acc_bus_as_", bus_as_, 0);
    chk("acc_bus_addr", bus_addr, 0);
    chk("acc_if_en", if_en, 0);
    tick();
    chk("s0_insn", if_insn, 32'h1000);
    chk("s0_pc", if_pc, 1);
    chk("s0_en", if_en, 1);
    tick();
    chk("s1_insn", if_insn, 32'h1001);
    chk("s1_pc", if_pc, 2);
    tick();
    chk("s2_insn", if_insn, 32'h1002);
    chk("s2_pc", if_pc, 3);

    // Two wait states per access: addresses 3, 4, 5
    wait_states = 2;
    done        = 0;
    busy_cnt    = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      #1;
      chk("ws_insn", if_insn, 32'h1002 + done);
      chk("ws_addr", bus_addr, 3 + done);
      chk("ws_as_", bus_as_, 0);
      if (busy) busy_cnt++;
      if (!bus_rdy_) done++;
    end
    chk("ws_busy_cycles", busy_cnt, 6);
    chk("ws_fetches", done, 3);

    // Stall asserted in the cycle address 5 returns
    stall = 1'b1;
    tick();
    chk("hold_insn", if_insn, 32'h1004);
    chk("hold_pc", if_pc, 5);
    chk("hold_busy", busy, 0);
    chk("hold_as_", bus_as_, 1);
    chk("hold_req_", bus_req_, 0);
    tick();
    tick();
    chk("hold3_insn", if_insn, 32'h1004);
    stall = 1'b0;
    tick();
    chk("rel_insn", if_insn, 32'h1005);
    chk("rel_pc", if_pc, 6);
    chk("rel_en", if_en, 1);
    chk("rel_addr", bus_addr, 6);

    // Branch in the cycle address 8 is delivered
    wait_states = 0;
    tick();
    chk("b6_insn", if_insn, 32'h1006);
    tick();
    chk("b7_insn", if_insn, 32'h1007);
    br_taken = 1'b1;
    br_addr  = 30'h40;
    tick();
    br_taken = 1'b0;
    br_addr  = '0;
    chk("slot_insn", if_insn, 32'h1008);
    chk("slot_pc", if_pc, 9);
    chk("slot_en", if_en, 1);
    chk("br_addr_out", bus_addr, 30'h40);
    tick();
    chk("tgt_insn", if_insn, 32'h1040);
    chk("tgt_pc", if_pc, 30'h41);

    // Flush while address 0x41 is waiting on ready
    wait_states = 2;
    @(negedge clk);
    #1;
    chk("pre_flush_rdy_", bus_rdy_, 1);
    flush  = 1'b1;
    new_pc = 30'h100;
    tick();
    flush  = 1'b0;
    chk("fl_en", if_en, 0);
    chk("fl_insn", if_insn, 0);
    chk("fl_busy", busy, 1);
    chk("fl_addr", bus_addr, 30'h100);
    tick();
    chk("drain_en", if_en, 0);
    tick();
    chk("drain_done_en", if_en, 0);
    chk("drain_done_insn", if_insn, 0);
    chk("drain_done_addr", bus_addr, 30'h100);
    tick();
    tick();
    chk("new_wait_en", if_en, 0);
    tick();
    chk("new_insn", if_insn, 32'h1100);
    chk("new_pc", if_pc, 30'h101);
    chk("new_en", if_en, 1);

    // Wrap-around at the top word address
    wait_states = 0;
    flush       = 1'b1;
    new_pc      = 30'h3FFF_FFFF;
    tick();
    flush  = 1'b0;
    new_pc = '0;
    chk("wr_fl_en", if_en, 0);
    chk("wr_addr", bus_addr, 30'h3FFF_FFFF);
    tick();
    chk("wr_insn", if_insn, 32'h4000_0FFF);
    chk("wr_pc", if_pc, 0);
    chk("wr_next_addr", bus_addr, 0);
    tick();
    chk("wr0_insn", if_insn, 32'h1000);
    chk("wr0_pc", if_pc, 1);

    // Asynchronous reset mid-access
    reset_ = 1'b0;
    #1;
    chk("ar_en", if_en, 0);
    chk("ar_pc", if_pc, 0);
    chk("ar_insn", if_insn, 0);
    chk("ar_req_", bus_req_, 1);
    chk("ar_as_", bus_as_, 1);
    chk("ar_busy", busy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
